// File: rtl/valid_skew_seq_ctrl_pkg.sv
// rtl/valid_skew_seq_ctrl_pkg.sv - shared types and constants for the valid-pipeline sequencer
package valid_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_RUN       = 3'd2,
    ST_TILE_END  = 3'd3,
    ST_WAIT_TILE = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [2:0] LANE_LOAD  = 3'b001;
  localparam logic [2:0] LANE_LAYER = 3'b010;

  localparam logic [1:0] MODE_LOAD  = 2'd0;
  localparam logic [1:0] MODE_LAYER = 2'd1;

  function automatic logic [2:0] lane_code(input logic [1:0] mode);
    return (mode == MODE_LAYER) ? LANE_LAYER : LANE_LOAD;
  endfunction

  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode == MODE_LOAD) || (mode == MODE_LAYER);
  endfunction

endpackage

// File: rtl/valid_skew_seq_ctrl_if.sv
// rtl/valid_skew_seq_ctrl_if.sv - controller-side handshake and MAC valid bus
interface valid_skew_seq_ctrl_if #(
  parameter int N_MACS    = 4,
  parameter int SEL_W     = 3,
  parameter int NUM_TILES = 1
);
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  logic                      start;
  logic [1:0]                mode;
  logic                      load_ready;
  logic                      next_tile_ready;
  logic                      abort;
  logic [N_MACS*SEL_W-1:0]   valid_ctrl;
  logic [TILE_W-1:0]         tile_idx;
  logic                      busy;
  logic                      tile_done;
  logic                      done;

  modport master (
    output start, mode, load_ready, next_tile_ready, abort,
    input  valid_ctrl, tile_idx, busy, tile_done, done
  );

  modport slave (
    input  start, mode, load_ready, next_tile_ready, abort,
    output valid_ctrl, tile_idx, busy, tile_done, done
  );

endinterface

// File: rtl/valid_skew_seq_ctrl_lane_decode.sv
// rtl/valid_skew_seq_ctrl_lane_decode.sv - per-lane skewed window decode of the run counter
module valid_lane_decode #(
  parameter int N      = 4,
  parameter int N_MACS = 4,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = $clog2(N + N_MACS)
) (
  input  logic [CNT_W-1:0]         cnt_i,
  input  logic                     run_i,
  input  logic [2:0]               code_i,
  output logic [N_MACS*SEL_W-1:0]  valid_ctrl_o
);

  logic [SEL_W-1:0] sel;
  assign sel = SEL_W'(code_i);

  // Lane k is open for N counts starting at count k, giving the diagonal skew.
  for (genvar k = 0; k < N_MACS; k++) begin : g_lane
    logic in_win;
    assign in_win = run_i && (int'(cnt_i) >= k) && (int'(cnt_i) < k + N);
    assign valid_ctrl_o[k*SEL_W +: SEL_W] = in_win ? sel : '0;
  end

endmodule

// File: rtl/valid_skew_seq_ctrl.sv
// rtl/valid_skew_seq_ctrl.sv - tiled, abortable valid-pipeline sequencer for the MAC chain
module valid_skew_seq_ctrl
  import valid_seq_pkg::*;
#(
  parameter int N         = 4,
  parameter int N_MACS    = 4,
  parameter int SEL_W     = 3,
  parameter int NUM_TILES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  valid_skew_seq_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(N + N_MACS);
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N + N_MACS - 2);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
  logic [1:0]          mode_q, mode_d;
  logic                busy_q, tile_done_q, done_q;
  logic [N_MACS*SEL_W-1:0] valid_ctrl;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tile_idx_d = tile_idx_q;
    mode_d     = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && mode_legal(bus.mode)) begin
          state_d    = ST_ARMED;
          mode_d     = bus.mode;
          tile_idx_d = '0;
        end
      end
      ST_ARMED: begin
        if (bus.load_ready) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_TILE_END;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TILE_END: begin
        if (tile_idx_q == TILE_LAST) begin
          state_d = ST_DONE;
        end else begin
          tile_idx_d = tile_idx_q + TILE_W'(1);
          state_d    = ST_WAIT_TILE;
        end
      end
      ST_WAIT_TILE: begin
        if (bus.next_tile_ready) begin
          state_d = ST_ARMED;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a start seen in the same cycle.
    if (bus.abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      tile_idx_d = '0;
      mode_d     = mode_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tile_idx_q  <= '0;
      mode_q      <= MODE_LOAD;
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tile_idx_q  <= tile_idx_d;
      mode_q      <= mode_d;
      busy_q      <= (state_d == ST_ARMED) || (state_d == ST_RUN) ||
                     (state_d == ST_TILE_END) || (state_d == ST_WAIT_TILE);
      tile_done_q <= (state_d == ST_TILE_END);
      done_q      <= (state_d == ST_DONE);
    end
  end

  valid_lane_decode #(
    .N      (N),
    .N_MACS (N_MACS),
    .SEL_W  (SEL_W),
    .CNT_W  (CNT_W)
  ) u_lane_decode (
    .cnt_i        (cnt_q),
    .run_i        (state_q == ST_RUN),
    .code_i       (lane_code(mode_q)),
    .valid_ctrl_o (valid_ctrl)
  );

  assign bus.valid_ctrl = valid_ctrl;
  assign bus.tile_idx   = tile_idx_q;
  assign bus.busy       = busy_q;
  assign bus.tile_done  = tile_done_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_valid_skew_seq_ctrl.sv
// tb/tb_valid_skew_seq_ctrl.sv - directed table and corner-case bench for valid_skew_seq_ctrl
module tb_valid_skew_seq_ctrl;

  localparam int N         = 4;
  localparam int N_MACS    = 4;
  localparam int SEL_W     = 3;
  localparam int NUM_TILES = 2;
  localparam int VC_W      = N_MACS * SEL_W;

  typedef struct {
    logic            start;
    logic [1:0]      mode;
    logic            lr;
    logic            ntr;
    logic            ab;
    logic [VC_W-1:0] vc;
    logic            tile;
    logic            busy;
    logic            td;
    logic            done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  valid_skew_seq_ctrl_if #(.N_MACS(N_MACS), .SEL_W(SEL_W), .NUM_TILES(NUM_TILES)) bus ();

  valid_skew_seq_ctrl #(
    .N(N), .N_MACS(N_MACS), .SEL_W(SEL_W), .NUM_TILES(NUM_TILES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];
  logic [VC_W-1:0] load_seq [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string pfx, input logic [VC_W-1:0] vc, input logic tile,
                           input logic busy, input logic td, input logic done);
    check({pfx, "_vc"},   32'(bus.valid_ctrl), 32'(vc));
    check({pfx, "_tile"}, 32'(bus.tile_idx),   32'(tile));
    check({pfx, "_busy"}, 32'(bus.busy),       32'(busy));
    check({pfx, "_td"},   32'(bus.tile_done),  32'(td));
    check({pfx, "_done"}, 32'(bus.done),       32'(done));
  endtask

  task automatic drive(input logic s, input logic [1:0] m, input logic lr, input logic ntr, input logic ab);
    bus.start           = s;
    bus.mode            = m;
    bus.load_ready      = lr;
    bus.next_tile_ready = ntr;
    bus.abort           = ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic [1:0] m, input logic [VC_W-1:0] vc,
                              input logic tile, input logic busy, input logic td, input logic done);
    vec_t v;
    v.start = s;  v.mode = m;  v.lr = 1'b1;  v.ntr = 1'b1;  v.ab = 1'b0;
    v.vc = vc;    v.tile = tile;  v.busy = busy;  v.td = td;  v.done = done;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic found;

    load_seq = '{12'h001, 12'h009, 12'h049, 12'h249, 12'h248, 12'h240, 12'h200};

    drive(0, 2'd0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Full two-tile load job with both handshakes held high.
    tbl.push_back(mk(1, 2'd0, '0, 0, 1, 0, 0));
    for (int t = 0; t < NUM_TILES; t++) begin
      if (t > 0) tbl.push_back(mk(0, 2'd0, '0, 1'(t), 1, 0, 0));
      for (int c = 0; c < 7; c++) tbl.push_back(mk(0, 2'd0, load_seq[c], 1'(t), 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, '0, 1'(t), 1, 1, 0));
      if (t < NUM_TILES - 1) tbl.push_back(mk(0, 2'd0, '0, 1'(t + 1), 1, 0, 0));
    end
    tbl.push_back(mk(0, 2'd0, '0, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].mode, tbl[i].lr, tbl[i].ntr, tbl[i].ab);
      tick();
      check_all($sformatf("row%0d", i), tbl[i].vc, tbl[i].tile, tbl[i].busy, tbl[i].td, tbl[i].done);
    end
    drive(0, 2'd0, 1, 1, 0);
    tick();
    check("post_job_done", 32'(bus.done), 0);
    check("post_job_busy", 32'(bus.busy), 0);

    // Layer mode with load_ready and next_tile_ready stalls; start during RUN ignored.
    drive(1, 2'd1, 0, 0, 0);
    tick();
    check_all("lay_armed", '0, 0, 1, 0, 0);
    drive(0, 2'd1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("lr_stall%0d", i), '0, 0, 1, 0, 0);
    end
    drive(0, 2'd1, 1, 0, 0);
    tick();
    check("lay_cnt0", 32'(bus.valid_ctrl), 32'h002);
    repeat (3) tick();
    check("lay_cnt3", 32'(bus.valid_ctrl), 32'h492);
    repeat (3) tick();
    check("lay_cnt6", 32'(bus.valid_ctrl), 32'h400);
    tick();
    check_all("lay_tend0", '0, 0, 1, 1, 0);
    tick();
    check_all("lay_wait", '0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("ntr_stall%0d", i), '0, 1, 1, 0, 0);
    end
    drive(0, 2'd1, 1, 1, 0);
    tick();
    check_all("lay_rearm", '0, 1, 1, 0, 0);
    tick();
    check("lay_t1_cnt0", 32'(bus.valid_ctrl), 32'h002);
    drive(1, 2'd0, 1, 1, 0);
    tick();
    check("start_in_run", 32'(bus.valid_ctrl), 32'h012);
    drive(0, 2'd0, 1, 1, 0);
    repeat (5) tick();
    check("lay_t1_cnt6", 32'(bus.valid_ctrl), 32'h400);
    tick();
    check_all("lay_tend1", '0, 1, 1, 1, 0);
    tick();
    check_all("lay_done", '0, 1, 0, 0, 1);
    tick();
    check("lay_done_gone", 32'(bus.done), 0);

    // Abort mid-RUN, then illegal requests in IDLE.
    drive(1, 2'd0, 1, 1, 0);
    tick();
    drive(0, 2'd0, 1, 1, 0);
    repeat (3) tick();
    check("abort_pre_cnt2", 32'(bus.valid_ctrl), 32'h049);
    drive(0, 2'd0, 1, 1, 1);
    tick();
    check_all("abort", '0, 0, 0, 0, 0);
    drive(0, 2'd0, 1, 1, 0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | bus.done | bus.tile_done | bus.busy;
    end
    check("no_done_after_abort", 32'(seen), 0);
    drive(1, 2'd0, 1, 1, 1);
    tick();
    check("start_abort_busy", 32'(bus.busy), 0);
    drive(0, 2'd0, 1, 1, 0);
    tick();
    check("start_abort_busy2", 32'(bus.busy), 0);
    drive(1, 2'd2, 1, 1, 0);
    tick();
    check("mode2_busy", 32'(bus.busy), 0);
    drive(1, 2'd3, 1, 1, 0);
    tick();
    check("mode3_busy", 32'(bus.busy), 0);
    drive(0, 2'd0, 1, 1, 0);
    tick();
    check("illegal_idle_busy", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of the second tile's RUN.
    drive(1, 2'd0, 1, 1, 0);
    tick();
    drive(0, 2'd0, 1, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.tile_idx == 1'b1 && bus.valid_ctrl != '0) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_tile1_run", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", '0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 2'd0, 1, 1, 0);
    tick();
    check_all("rst_restart_armed", '0, 0, 1, 0, 0);
    drive(0, 2'd0, 1, 1, 0);
    tick();
    check_all("rst_restart_run", 12'h001, 0, 1, 0, 0);
    drive(0, 2'd0, 1, 1, 1);
    tick();
    check("final_abort_busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/valid_skew_seq_ctrl.md
# valid_skew_seq_ctrl

Parametrised valid-pipeline sequencer for the systolic MAC chain. It generalises the fixed two-MAC load sequencer to `N_MACS` lanes, with the following additions:
- per-lane skewed valid windows of length `N`;
- load or layer lane codes;
- iteration over `NUM_TILES` row tiles with an inter-tile handshake;
- abort.

It sits between the top-level controller (start/mode/next-tile handshakes) and the MAC array's `valid_ctrl` bus.

## Interface
Parameters:
- `N`, 4: stream length per tile, i.e. cycles each lane is valid (≥1).
- `N_MACS`, 4: number of MAC lanes in the chain (≥1).
- `SEL_W`, 3: select bits per lane, packed `{lane N_MACS-1, …, lane 0}`.
- `NUM_TILES`, 1: tiles per job (1..8).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `mode`  in  2  0 = load, 1 = layer, 2/3 reserved; latched with `start`.
- `load_ready`  in  1  weight interface ready; releases ARMED.
- `next_tile_ready`  in  1  tile controller ready; releases WAIT_TILE.
- `abort`  in  1  synchronous job cancel, highest priority.
- `valid_ctrl`  out  `N_MACS*SEL_W`  per-lane operand select.
- `tile_idx`  out  `TILE_W = max(1,$clog2(NUM_TILES))`  current tile.
- `busy`  out  1  job in progress.
- `tile_done`  out  1  one-cycle pulse at end of each tile.
- `done`  out  1  one-cycle pulse at end of the job.

## Operation
- States are IDLE, ARMED, RUN, TILE_END, WAIT_TILE and DONE.
- IDLE: on `start` with `mode` ∈ {0,1}, latch `mode_q`, set `tile_idx` = 0 and go to ARMED.
  - `start` with reserved mode is ignored.
  - `start` in any other state is ignored.
- ARMED: wait for `load_ready`. When it is high, clear `cnt` and go to RUN.
- RUN: `cnt` increments by 1 each cycle from 0 to `N+N_MACS-2`.
  - Lane k carries the lane code iff k ≤ `cnt` < k+N; otherwise it carries 0.
  - After the last count, go to TILE_END.
- Lane code is `LANE_LOAD` = 3'b001 (`a_in_0`) when `mode_q` = 0, and `LANE_LAYER` = 3'b010 (`a_in_1`) when `mode_q` = 1. Bits above bit 2 of a lane are zero when `SEL_W` > 3.
- TILE_END: `tile_done` = 1.
  - If `tile_idx` = `NUM_TILES-1`, go to DONE.
  - Otherwise increment `tile_idx` and go to WAIT_TILE.
- WAIT_TILE: when `next_tile_ready` = 1, go to ARMED. The new tile re-waits on `load_ready`.
- DONE: `done` = 1, then go to IDLE.
- `abort` = 1 in any state means the next state is IDLE, with `cnt` and `tile_idx` cleared.
  - No `tile_done` or `done` is issued for the aborted job.
  - `abort` with `start` in IDLE: abort wins and the job is not accepted.
- `cnt` width is `$clog2(N+N_MACS)`. There is no wrap inside RUN. `tile_idx` never exceeds `NUM_TILES-1`.

## Timing
- All outputs are Moore decodes of registered state, `cnt`, `mode_q` and `tile_idx`. There are no combinational input-to-output paths.
- Reset (`rst_n` low, immediately and asynchronously):
  - state = IDLE;
  - `valid_ctrl`, `tile_idx`, `busy`, `tile_done` and `done` all = 0;
  - `mode_q` = 0.
  - Reset mid-job discards the job.
- `busy` = 1 in ARMED, RUN, TILE_END and WAIT_TILE. It rises the cycle after the accepted `start`. It is 0 in IDLE and DONE.
- Latency: with `load_ready` already high, lane 0 is first valid 2 cycles after the `start` edge (IDLE→ARMED→RUN).
- RUN lasts exactly `N+N_MACS-1` cycles per tile.
- `done` follows the final `tile_done` by 1 cycle.
- `load_ready` and `next_tile_ready` are level-sampled. Holding them high adds no wait cycles.

## Structure
- Shared package `valid_seq_pkg` holds:
  - the state enum;
  - `LANE_LOAD` and `LANE_LAYER`;
  - mode constants `MODE_LOAD` = 2'd0 and `MODE_LAYER` = 2'd1.
- Sub-module `valid_lane_decode` (combinational) maps (`cnt`, `run`, lane code) to the packed `valid_ctrl` via a per-lane window compare. It is parametrised by `N`, `N_MACS` and `SEL_W`.
- FSM, counters and handshakes live in the top module.

## Test plan
All scenarios use N = 4, N_MACS = 4, SEL_W = 3 and NUM_TILES = 2 unless stated.
- Load single tile: `start`, `mode` = 0, `load_ready` held 1 →
  - RUN for 7 cycles;
  - `valid_ctrl` at `cnt` = 0,1,2,3,4,5,6 is 0x001, 0x009, 0x049, 0x249, 0x248, 0x240, 0x200;
  - `tile_done` pulses once, `tile_idx` → 1, state WAIT_TILE.
- Layer mode: same stimulus with `mode` = 1 → at `cnt` = 3, `valid_ctrl` = 0x492; lanes use bit 1 only.
- Handshake stalls: `load_ready` low for 5 cycles after `start` → ARMED held, `busy` = 1, `valid_ctrl` = 0. `next_tile_ready` delayed 3 cycles → WAIT_TILE held with no valids.
- Two tiles: full job → `tile_done` twice, with `tile_idx` 0 then 1; `done` exactly once, 1 cycle after the second `tile_done`; `busy` low with `done`.
- Abort and illegal requests:
  - `abort` at `cnt` = 2 → `valid_ctrl` = 0 and `busy` = 0 the next cycle, no `done`;
  - `start` during RUN → ignored;
  - `start` with `abort` in IDLE → ignored;
  - `start` with `mode` = 2 → ignored.
- Async reset: `rst_n` low mid-RUN (between edges) → all outputs 0 immediately. After release, a fresh `start` runs a normal job from `tile_idx` = 0.
